// File: rtl/optic_flow_pkg.sv
// Shared types for the optic-flow binarizer, the optic-flow CI and their benches.
package optic_flow_pkg;

  localparam int unsigned SEG_WIDTH   = 16;
  localparam int unsigned PIXEL_WIDTH = 8;

  typedef logic [SEG_WIDTH-1:0] seg_t;

  typedef struct packed {
    seg_t up;
    seg_t down;
  } flow_word_t;

endpackage

// File: rtl/optic_flow_line_buffer.sv
// Single-port segment line buffer with registered read; holds the even row of a row pair.
module optic_flow_line_buffer
  import optic_flow_pkg::*;
#(
  parameter int unsigned Depth     = 40,
  parameter int unsigned AddrWidth = 6
) (
  input  logic                 clock,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write_en,
  input  seg_t                 write_data,
  input  logic                 read_en,
  output seg_t                 read_data
);

  seg_t mem [Depth];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[addr] <= write_data;
    end
    if (read_en) begin
      read_data <= mem[addr];
    end
  end

endmodule

// File: rtl/optic_flow_binarizer.sv
// Thresholds pixels, packs 16-pixel segments and pairs even/odd rows into {up, down} words.
// Optional frame ones-count output is enabled by defining OPTIC_FLOW_BIN_STATS_EN.
module optic_flow_binarizer
  import optic_flow_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 640
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  input  logic                   enable,
  input  logic                   sof,
  input  logic                   sol,
  input  logic                   pixelValid,
  input  logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [31:0]            outData,
  output logic                   outLast,
  output logic                   overflow,
`ifdef OPTIC_FLOW_BIN_STATS_EN
  output logic [19:0]            onesCount,
`endif
  input  logic                   clearOverflow
);

  localparam int unsigned SEG_COUNT      = LINE_WIDTH / SEG_WIDTH;
  localparam int unsigned COL_WIDTH      = $clog2(LINE_WIDTH + 1);
  localparam int unsigned SEG_ADDR_WIDTH = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;
  localparam logic [COL_WIDTH-1:0]      COL_LIMIT = COL_WIDTH'(LINE_WIDTH);
  localparam logic [SEG_ADDR_WIDTH-1:0] LAST_SEG  = SEG_ADDR_WIDTH'(SEG_COUNT - 1);

  logic [COL_WIDTH-1:0]      col_q, col_d, col_cur;
  logic [SEG_WIDTH-2:0]      shift_q, shift_d, shift_cur;
  logic                      row_odd_q, row_odd_d;
  logic                      first_sol_q, first_sol_d;
  logic                      line_start, accept, pix_bit, seg_done;
  logic [SEG_ADDR_WIDTH-1:0] seg_idx;
  seg_t                      seg_word;

  logic       s1_valid_q, s1_valid_d;
  logic       s1_last_q, s1_last_d;
  seg_t       s1_down_q, s1_down_d;
  seg_t       s1_up;
  flow_word_t out_word_q, out_word_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       overflow_q, overflow_d;

  // A strobe restarts the line in the same cycle, so a coincident pixel is column 0.
  assign line_start = enable && (sof || sol);
  assign col_cur    = line_start ? '0 : col_q;
  assign shift_cur  = line_start ? '0 : shift_q;
  assign pix_bit    = pixel > threshold;
  assign accept     = enable && pixelValid && (col_cur < COL_LIMIT);
  assign seg_idx    = col_cur[4 +: SEG_ADDR_WIDTH];
  assign seg_done   = accept && (col_cur[3:0] == 4'hF);
  assign seg_word   = {shift_cur, pix_bit};

  always_comb begin
    col_d       = accept ? col_cur + 1'b1 : col_cur;
    shift_d     = accept ? {shift_cur[SEG_WIDTH-3:0], pix_bit} : shift_cur;
    row_odd_d   = row_odd_q;
    first_sol_d = first_sol_q;
    if (enable && sof) begin
      // A coincident sol is the first line of the frame and must not toggle parity.
      row_odd_d   = 1'b0;
      first_sol_d = !sol;
    end else if (enable && sol) begin
      if (first_sol_q) begin
        first_sol_d = 1'b0;
      end else begin
        row_odd_d = !row_odd_q;
      end
    end
  end

  optic_flow_line_buffer #(
    .Depth     (SEG_COUNT),
    .AddrWidth (SEG_ADDR_WIDTH)
  ) u_line_buffer (
    .clock      (clock),
    .addr       (seg_idx),
    .write_en   (seg_done && !row_odd_q),
    .write_data (seg_word),
    .read_en    (seg_done && row_odd_q),
    .read_data  (s1_up)
  );

  always_comb begin
    s1_valid_d  = seg_done && row_odd_q;
    s1_down_d   = s1_valid_d ? seg_word : s1_down_q;
    s1_last_d   = s1_valid_d ? (seg_idx == LAST_SEG) : s1_last_q;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !outReady;
    overflow_d  = clearOverflow ? 1'b0 : overflow_q;
    if (s1_valid_q) begin
      if (!out_valid_q || outReady) begin
        out_word_d  = '{up: s1_up, down: s1_down_q};
        out_last_d  = s1_last_q;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      shift_q     <= '0;
      row_odd_q   <= 1'b0;
      first_sol_q <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_down_q   <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      shift_q     <= shift_d;
      row_odd_q   <= row_odd_d;
      first_sol_q <= first_sol_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_down_q   <= s1_down_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign outValid = out_valid_q;
  assign outData  = out_word_q;
  assign outLast  = out_last_q;
  assign overflow = overflow_q;

`ifdef OPTIC_FLOW_BIN_STATS_EN
  logic [19:0] ones_run_q, ones_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ones_run_q <= '0;
      ones_q     <= '0;
    end else if (enable && sof) begin
      ones_q     <= ones_run_q;
      ones_run_q <= {19'd0, accept && pix_bit};
    end else if (accept && pix_bit) begin
      ones_run_q <= ones_run_q + 20'd1;
    end
  end

  assign onesCount = ones_q;
`endif

endmodule

// File: tb/tb_optic_flow_binarizer.sv
// Directed bench for optic_flow_binarizer at LINE_WIDTH=32 (two segments per line).
module tb_optic_flow_binarizer;

  logic        clock = 1'b0;
  logic        reset, enable, sof, sol, pixelValid, outReady, clearOverflow;
  logic [7:0]  threshold, pixel;
  logic        outValid, outLast, overflow;
  logic [31:0] outData;
`ifdef OPTIC_FLOW_BIN_STATS_EN
  logic [19:0] onesCount;
`endif

  int total = 0;
  int bad   = 0;
  logic [32:0] got_q[$];

  always #5 clock = ~clock;

  optic_flow_binarizer #(
    .LINE_WIDTH (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .threshold     (threshold),
    .enable        (enable),
    .sof           (sof),
    .sol           (sol),
    .pixelValid    (pixelValid),
    .pixel         (pixel),
    .outValid      (outValid),
    .outReady      (outReady),
    .outData       (outData),
    .outLast       (outLast),
    .overflow      (overflow),
`ifdef OPTIC_FLOW_BIN_STATS_EN
    .onesCount     (onesCount),
`endif
    .clearOverflow (clearOverflow)
  );

  // Words accepted downstream, recorded as {last, data}.
  always @(negedge clock) begin
    if (!reset && outValid && outReady) got_q.push_back({outLast, outData});
  end

  typedef struct {
    logic [7:0]  thr, hi, lo;
    logic [15:0] up0, up1, dn0, dn1;
    logic [31:0] exp0, exp1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pix(input logic [7:0] v, input logic s_sol);
    sol = s_sol; pixelValid = 1'b1; pixel = v;
    @(posedge clock); #1;
    sol = 1'b0; pixelValid = 1'b0;
  endtask

  task automatic seg(input logic [15:0] pat, input logic [7:0] hi, input logic [7:0] lo,
                     input logic first_sol);
    for (int i = 0; i < 16; i++) pix(pat[15-i] ? hi : lo, first_sol && (i == 0));
  endtask

  task automatic row(input logic [15:0] p0, input logic [15:0] p1,
                     input logic [7:0] hi, input logic [7:0] lo);
    seg(p0, hi, lo, 1'b1);
    seg(p1, hi, lo, 1'b0);
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    @(posedge clock); #1;
    sof = 1'b0;
  endtask

  task automatic check_pair(input string name, input logic [31:0] e0, input logic [31:0] e1);
    check({name, " count"}, 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check({name, " word0"}, 64'(got_q[0]), {31'd0, 1'b0, e0});
      check({name, " word1"}, 64'(got_q[1]), {31'd0, 1'b1, e1});
    end
  endtask

  initial begin
    logic [15:0] odd_pat;
    vecs[0] = '{8'd128, 8'd255, 8'd0,   16'hC910, 16'hFFFF, 16'h54A4, 16'h0001,
                32'hC91054A4, 32'hFFFF0001};
    vecs[1] = '{8'd128, 8'd128, 8'd0,   16'hAAAA, 16'hFFFF, 16'h5555, 16'hFFFF,
                32'h00000000, 32'h00000000};
    vecs[2] = '{8'd127, 8'd128, 8'd0,   16'hFFFF, 16'h8001, 16'h1234, 16'hF00F,
                32'hFFFF1234, 32'h8001F00F};
    vecs[3] = '{8'd200, 8'd201, 8'd200, 16'h0F0F, 16'h0000, 16'h3C3C, 16'hFFFF,
                32'h0F0F3C3C, 32'h0000FFFF};

    reset = 1'b1; enable = 1'b1; sof = 1'b0; sol = 1'b0; pixelValid = 1'b0; pixel = '0;
    threshold = 8'd128; outReady = 1'b1; clearOverflow = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(3);
    check("reset outValid", 64'(outValid), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset outData", 64'(outData), 64'd0);
    check("reset outLast", 64'(outLast), 64'd0);
`ifdef OPTIC_FLOW_BIN_STATS_EN
    check("reset onesCount", 64'(onesCount), 64'd0);
`endif

    // Latency: word appears two cycles after the 16th odd-row pixel.
    got_q.delete();
    pulse_sof();
    row(16'hC910, 16'hFFFF, 8'd255, 8'd0);
    odd_pat = 16'h54A4;
    for (int i = 0; i < 16; i++) pix(odd_pat[15-i] ? 8'd255 : 8'd0, i == 0);
    check("latency early", 64'(outValid), 64'd0);
    idle(1);
    check("latency valid", 64'(outValid), 64'd1);
    check("latency data", 64'(outData), 64'hC91054A4);
    check("latency last", 64'(outLast), 64'd0);
    idle(1);
    check("valid falls", 64'(outValid), 64'd0);
    seg(16'h0001, 8'd255, 8'd0, 1'b0);
    idle(4);
    check_pair("latency pair", 32'hC91054A4, 32'hFFFF0001);

    // Table: one even row and one odd row per vector.
    pulse_sof();
    for (int v = 0; v < 4; v++) begin
      threshold = vecs[v].thr;
      got_q.delete();
      row(vecs[v].up0, vecs[v].up1, vecs[v].hi, vecs[v].lo);
      row(vecs[v].dn0, vecs[v].dn1, vecs[v].hi, vecs[v].lo);
      idle(4);
      check_pair($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1);
    end

    // Backpressure: first word held, second dropped.
    threshold = 8'd128;
    got_q.delete();
    row(16'hA0A0, 16'h0B0B, 8'd255, 8'd0);
    outReady = 1'b0;
    row(16'h0C0C, 16'hD0D0, 8'd255, 8'd0);
    idle(3);
    check("held valid", 64'(outValid), 64'd1);
    check("held data", 64'(outData), 64'hA0A00C0C);
    check("held last", 64'(outLast), 64'd0);
    check("overflow set", 64'(overflow), 64'd1);
    outReady = 1'b1;
    idle(1);
    check("drain valid", 64'(outValid), 64'd0);
    check("drain count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("drain word", 64'(got_q[0]), 64'h0A0A00C0C);
    check("overflow sticky", 64'(overflow), 64'd1);
    clearOverflow = 1'b1;
    idle(1);
    clearOverflow = 1'b0;
    check("overflow cleared", 64'(overflow), 64'd0);

    // Partial segment cut by sol must not bleed into the next line.
    row(16'h1357, 16'h2468, 8'd255, 8'd0);
    row(16'hAAAA, 16'h5555, 8'd255, 8'd0);
    idle(4);
    got_q.delete();
    for (int i = 0; i < 8; i++) pix(8'd255, i == 0);
    row(16'h00F0, 16'h0F00, 8'd255, 8'd0);
    idle(4);
    check_pair("partial", 32'h135700F0, 32'h24680F00);

    // sof in the middle of an odd row restarts parity.
    row(16'h7777, 16'h7777, 8'd255, 8'd0);
    for (int i = 0; i < 10; i++) pix(8'd255, i == 0);
    idle(4);
    got_q.delete();
    pulse_sof();
    row(16'hC3C3, 16'h0FF0, 8'd255, 8'd0);
    row(16'h8888, 16'h1111, 8'd255, 8'd0);
    idle(4);
    check_pair("sof restart", 32'hC3C38888, 32'h0FF01111);

`ifdef OPTIC_FLOW_BIN_STATS_EN
    pulse_sof();
    row(16'hFFFF, 16'hFFFF, 8'd255, 8'd0);
    row(16'hF800, 16'h0000, 8'd255, 8'd0);
    idle(4);
    pulse_sof();
    check("onesCount", 64'(onesCount), 64'd37);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
